tl_mem_responder: RTL



---
 rtl/tl_mem_responder.sv | 343 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/tl_mem_responder.sv
// tl_mem_responder: TileLink-C manager endpoint backed by a small register-array
// memory. It serves Get/PutFull/PutPartial/AcquireBlock/AcquirePerm on A and
// Release/ReleaseData on C, answers on D and consumes GrantAck on E. It never
// probes, so the B channel is tied off. One transaction is in flight at a time.
// Optional: define TL_MEM_PERF_CNT_EN to add the perf_grants/perf_denied counters.

module tl_mem_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_BEATS = 256,
    parameter logic [3:0]  GRANT_SINK  = 4'd0
) (
    input  logic         clock,
    input  logic         reset,
    // A channel
    input  logic         a_valid,
    output logic         a_ready,
    input  logic [2:0]   a_opcode,
    input  logic [2:0]   a_param,
    input  logic [3:0]   a_size,
    input  logic [4:0]   a_source,
    input  logic [31:0]  a_address,
    input  logic [15:0]  a_mask,
    input  logic [127:0] a_data,
    // B channel (never used)
    output logic         b_valid,
    input  logic         b_ready,
    output logic [2:0]   b_opcode,
    output logic [1:0]   b_param,
    output logic [3:0]   b_size,
    output logic [4:0]   b_source,
    output logic [31:0]  b_address,
    output logic [15:0]  b_mask,
    output logic         b_corrupt,
    // C channel
    input  logic         c_valid,
    output logic         c_ready,
    input  logic [2:0]   c_opcode,
    input  logic [2:0]   c_param,
    input  logic [3:0]   c_size,
    input  logic [4:0]   c_source,
    input  logic [31:0]  c_address,
    input  logic [127:0] c_data,
    // D channel
    output logic         d_valid,
    input  logic         d_ready,
    output logic [2:0]   d_opcode,
    output logic [1:0]   d_param,
    output logic [3:0]   d_size,
    output logic [4:0]   d_source,
    output logic [3:0]   d_sink,
    output logic         d_denied,
    output logic [127:0] d_data,
    output logic         d_corrupt,
    // E channel
    input  logic         e_valid,
    output logic         e_ready,
    input  logic [3:0]   e_sink
`ifdef TL_MEM_PERF_CNT_EN
    ,
    output logic [31:0]  perf_grants,
    output logic [31:0]  perf_denied
`endif
);

    localparam int          IW      = $clog2(DEPTH_BEATS);
    localparam logic [32:0] MEM_END = {1'b0, ADDR_BASE} + 33'(DEPTH_BEATS) * 33'd16;

    localparam logic [2:0] A_PUT_FULL    = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] A_GET         = 3'd4;
    localparam logic [2:0] A_ACQ_BLOCK   = 3'd6;
    localparam logic [2:0] A_ACQ_PERM    = 3'd7;
    localparam logic [2:0] C_RELEASE_DATA = 3'd7;

    localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
    localparam logic [2:0] D_GRANT           = 3'd4;
    localparam logic [2:0] D_GRANT_DATA      = 3'd5;
    localparam logic [2:0] D_RELEASE_ACK     = 3'd6;

    typedef enum logic [2:0] {IDLE, A_WR, C_WR, RESP, WAIT_E} state_t;

    // Index of the last beat for a transfer size; sizes above 6 are denied and
    // treated as a single beat.
    function automatic logic [1:0] last_beat(input logic [3:0] size);
        case (size)
            4'd5:    return 2'd1;
            4'd6:    return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic out_of_range(input logic [31:0] addr, input logic [3:0] size);
        logic [32:0] end_addr;
        end_addr = {1'b0, addr} + (33'd1 << size);
        return (addr < ADDR_BASE) || (end_addr > MEM_END) || (size > 4'd6);
    endfunction

    // The beat counter only advances the low two index bits, so a burst wraps
    // inside its aligned block.
    function automatic logic [IW-1:0] beat_index(input logic [IW-1:0] base, input logic [1:0] cnt);
        return {base[IW-1:2], base[1:0] + cnt};
    endfunction

    logic [127:0] mem [DEPTH_BEATS];

    state_t       state, state_next;
    logic [1:0]   cnt, req_last, resp_last;
    logic [2:0]   resp_opcode;
    logic [3:0]   req_size;
    logic [4:0]   req_source;
    logic [IW-1:0] req_base;
    logic         req_denied, req_write, req_grant, req_resp_data;

    logic         sel_c;
    logic [3:0]   sel_size;
    logic [4:0]   sel_source;
    logic [31:0]  sel_addr, sel_offset;
    logic [IW-1:0] sel_base_idx;
    logic         sel_denied, sel_multi, sel_write, sel_grant, sel_resp_data;
    logic [2:0]   sel_resp_opcode;
    logic [1:0]   sel_last, sel_resp_last;

    logic         sel_fire, wr_fire, d_fire;
    logic         mem_we;
    logic [IW-1:0] mem_widx;
    logic [127:0] mem_wdata;
    logic [15:0]  mem_wmask;

    // Decode the request offered in IDLE (C wins over A).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sel_c           = c_valid;
        sel_size        = sel_c ? c_size : a_size;
        sel_source      = sel_c ? c_source : a_source;
        sel_addr        = sel_c ? c_address : a_address;
        sel_offset      = sel_addr - ADDR_BASE;
        sel_last        = last_beat(sel_size);
        sel_denied      = out_of_range(sel_addr, sel_size);
        sel_multi       = 1'b0;
        sel_write       = 1'b0;
        sel_grant       = 1'b0;
        sel_resp_data   = 1'b0;
        sel_resp_opcode = D_ACCESS_ACK;
        if (sel_c) begin
            sel_resp_opcode = D_RELEASE_ACK;
            sel_multi       = c_opcode[0];
            sel_write       = (c_opcode == C_RELEASE_DATA);
        end else begin
            case (a_opcode)
                A_PUT_FULL, A_PUT_PARTIAL: begin
                    sel_multi = 1'b1;
                    sel_write = 1'b1;
                end
                A_GET: begin
                    sel_resp_opcode = D_ACCESS_ACK_DATA;
                    sel_resp_data   = 1'b1;
                end
                A_ACQ_BLOCK: begin
                    sel_resp_opcode = D_GRANT_DATA;
                    sel_resp_data   = 1'b1;
                    sel_grant       = 1'b1;
                end
                A_ACQ_PERM: begin
                    sel_resp_opcode = D_GRANT;
                    sel_grant       = 1'b1;
                end
                default: begin
                    // Arithmetic, Logical and Intent are unsupported: consume and deny.
                    sel_multi  = 1'b1;
                    sel_denied = 1'b1;
                end
            endcase
        end
        sel_write     = sel_write && !sel_denied;
        sel_resp_last = sel_resp_data ? sel_last : 2'd0;
    end

    assign sel_base_idx = sel_offset[IW+3:4];

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        a_ready    = 1'b0;
        c_ready    = 1'b0;
        d_valid    = 1'b0;
        e_ready    = 1'b0;
        sel_fire   = 1'b0;
        wr_fire    = 1'b0;
        d_fire     = 1'b0;
        case (state)
            IDLE: begin
                c_ready  = c_valid || !a_valid;
                a_ready  = !c_valid;
                sel_fire = a_valid || c_valid;
                if (sel_fire) begin
                    if (sel_multi && (sel_last != 2'd0))
                        state_next = sel_c ? C_WR : A_WR;
                    else
                        state_next = RESP;
                end
            end
            A_WR: begin
                a_ready = 1'b1;
                wr_fire = a_valid;
                if (a_valid && (cnt == req_last)) state_next = RESP;
            end
            C_WR: begin
                c_ready = 1'b1;
                wr_fire = c_valid;
                if (c_valid && (cnt == req_last)) state_next = RESP;
            end
            RESP: begin
                d_valid = 1'b1;
                d_fire  = d_ready;
                if (d_ready && (cnt == resp_last)) state_next = req_grant ? WAIT_E : IDLE;
            end
            WAIT_E: begin
                e_ready = 1'b1;
                if (e_valid && (e_sink == GRANT_SINK)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Select the memory write for the current beat; a beat arriving with reset is dropped.
    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = sel_base_idx;
        mem_wdata = a_data;
        mem_wmask = a_mask;
        case (state)
            IDLE: begin
                mem_we    = sel_fire && sel_write;
                mem_wdata = sel_c ? c_data : a_data;
                mem_wmask = sel_c ? 16'hFFFF : a_mask;
            end
            A_WR: begin
                mem_we   = a_valid && req_write;
                mem_widx = beat_index(req_base, cnt);
            end
            C_WR: begin
                mem_we    = c_valid && req_write;
                mem_widx  = beat_index(req_base, cnt);
                mem_wdata = c_data;
                mem_wmask = 16'hFFFF;
            end
            default: ;
        endcase
        mem_we = mem_we && !reset;
    end

    // Byte-masked write into the array.
    always_ff @(posedge clock) begin
        // NOTE: the array has no reset on purpose; contents survive reset and stay unknown until written.
        if (mem_we) begin
            for (int b = 0; b < 16; b++) begin
                if (mem_wmask[b]) mem[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Request latch and beat counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt           <= 2'd0;
            req_last      <= 2'd0;
            resp_last     <= 2'd0;
            resp_opcode   <= D_ACCESS_ACK;
            req_size      <= 4'd0;
            req_source    <= 5'd0;
            req_base      <= '0;
            req_denied    <= 1'b0;
            req_write     <= 1'b0;
            req_grant     <= 1'b0;
            req_resp_data <= 1'b0;
        end else begin
            case (state)
                IDLE: if (sel_fire) begin
                    req_last      <= sel_last;
                    resp_last     <= sel_resp_last;
                    resp_opcode   <= sel_resp_opcode;
                    req_size      <= sel_size;
                    req_source    <= sel_source;
                    req_base      <= sel_base_idx;
                    req_denied    <= sel_denied;
                    req_write     <= sel_write;
                    req_grant     <= sel_grant;
                    req_resp_data <= sel_resp_data;
                    cnt           <= (sel_multi && (sel_last != 2'd0)) ? 2'd1 : 2'd0;
                end
                A_WR, C_WR: if (wr_fire) cnt <= (cnt == req_last) ? 2'd0 : cnt + 2'd1;
                RESP:       if (d_fire)  cnt <= (cnt == resp_last) ? 2'd0 : cnt + 2'd1;
                default: ;
            endcase
        end
    end

    assign d_opcode  = resp_opcode;
    assign d_param   = 2'd0;
    assign d_size    = req_size;
    assign d_source  = req_source;
    assign d_sink    = req_grant ? GRANT_SINK : 4'd0;
    assign d_denied  = req_denied;
    assign d_corrupt = 1'b0;
    assign d_data    = (req_resp_data && !req_denied) ? mem[beat_index(req_base, cnt)] : '0;

    assign b_valid   = 1'b0;
    assign b_opcode  = 3'd0;
    assign b_param   = 2'd0;
    assign b_size    = 4'd0;
    assign b_source  = 5'd0;
    assign b_address = 32'd0;
    assign b_mask    = 16'd0;
    assign b_corrupt = 1'b0;

    logic unused_inputs;
    assign unused_inputs = ^{a_param, c_param, b_ready, sel_offset[3:0], sel_offset[31:IW+4]};

`ifdef TL_MEM_PERF_CNT_EN
    logic d_last_fire;
    assign d_last_fire = d_fire && (cnt == resp_last);

    // Count granted and denied responses on their last D beat.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_grants <= 32'd0;
            perf_denied <= 32'd0;
        end else begin
            if (d_last_fire && req_grant)  perf_grants <= perf_grants + 32'd1;
            if (d_last_fire && req_denied) perf_denied <= perf_denied + 32'd1;
        end
    end
`endif

endmodule
